// File: rtl/response_park_pool.sv
// Shared R-beat parking pool: per-UID linked lists over one slot pool, a FIFO free list,
// complete-burst tracking, per-UID flush walker and occupancy reporting.
module response_park_pool #(
    parameter int NUM_UIDS   = 16,
    parameter int NUM_SLOTS  = 32,
    parameter int ID_WIDTH   = $clog2(NUM_UIDS),
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int SLOT_W     = $clog2(NUM_SLOTS),
    parameter int CNT_W      = $clog2(NUM_SLOTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [RESP_WIDTH-1:0] in_resp,
    input  logic                  in_last,
    input  logic                  pop_req,
    input  logic [ID_WIDTH-1:0]   pop_uid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RESP_WIDTH-1:0] out_resp,
    output logic                  out_last,
    output logic                  pop_ack,
    input  logic                  flush_req,
    input  logic [ID_WIDTH-1:0]   flush_uid,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic [CNT_W-1:0]      free_slots,
    output logic [NUM_UIDS-1:0]   burst_ready
);

    typedef enum logic [1:0] {F_IDLE, F_WALK, F_DONE} fstate_e;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fstate_e               fst_q;
    logic [ID_WIDTH-1:0]   fuid_q;

    logic [DATA_WIDTH-1:0] data_q [NUM_SLOTS];
    logic [RESP_WIDTH-1:0] resp_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  last_q;
    logic [SLOT_W-1:0]     next_q [NUM_SLOTS];

    logic [SLOT_W-1:0]     fl_q [NUM_SLOTS];
    logic [SLOT_W-1:0]     fl_rd_q, fl_wr_q;
    logic [CNT_W-1:0]      free_q, free_d;

    logic [SLOT_W-1:0]     head_q [NUM_UIDS];
    logic [SLOT_W-1:0]     head_d [NUM_UIDS];
    logic [SLOT_W-1:0]     tail_q [NUM_UIDS];
    logic [SLOT_W-1:0]     tail_d [NUM_UIDS];
    logic [CNT_W-1:0]      cnt_q  [NUM_UIDS];
    logic [CNT_W-1:0]      cnt_d  [NUM_UIDS];
    logic [CNT_W-1:0]      lcnt_q [NUM_UIDS];
    logic [CNT_W-1:0]      lcnt_d [NUM_UIDS];

    logic                  acc, rm, walk_free, push_empty, rm_last;
    logic [ID_WIDTH-1:0]   rm_uid;
    logic [SLOT_W-1:0]     new_slot, rm_slot, out_slot;

    assign flush_busy = (fst_q != F_IDLE);
    assign flush_done = (fst_q == F_DONE);
    assign free_slots = free_q;

    // Uses the registered count, so a slot freed this cycle is never reused this cycle.
    assign in_ready = (free_q != '0) && !flush_busy;
    assign acc      = in_valid && in_ready;
    assign new_slot = fl_q[fl_rd_q];

    assign out_valid = pop_req && !flush_busy && (cnt_q[pop_uid] != '0);
    assign pop_ack   = out_valid && out_ready;
    assign out_id    = pop_uid;
    assign out_slot  = head_q[pop_uid];
    assign out_data  = out_valid ? data_q[out_slot] : '0;
    assign out_resp  = out_valid ? resp_q[out_slot] : '0;
    assign out_last  = out_valid && last_q[out_slot];

    // Pops and flush frees are mutually exclusive: pops are blocked while flushing.
    assign walk_free = (fst_q == F_WALK) && (cnt_q[fuid_q] != '0);
    assign rm        = pop_ack || walk_free;
    assign rm_uid    = walk_free ? fuid_q : pop_uid;
    assign rm_slot   = head_q[rm_uid];
    assign rm_last   = last_q[rm_slot];

    assign push_empty = (cnt_q[in_id] == '0) ||
                        (rm && (rm_uid == in_id) && (cnt_q[in_id] == CNT_ONE));

    always_comb begin
        free_d = free_q;
        if (acc && !rm)      free_d = free_q - CNT_ONE;
        else if (!acc && rm) free_d = free_q + CNT_ONE;
        for (int u = 0; u < NUM_UIDS; u++) begin
            head_d[u] = head_q[u];
            tail_d[u] = tail_q[u];
            cnt_d[u]  = cnt_q[u];
            lcnt_d[u] = lcnt_q[u];
        end
        // Removal first so a push into a just-emptied list overrides the head.
        if (rm) begin
            cnt_d[rm_uid]  = cnt_d[rm_uid] - CNT_ONE;
            head_d[rm_uid] = next_q[rm_slot];
            if (rm_last) lcnt_d[rm_uid] = lcnt_d[rm_uid] - CNT_ONE;
        end
        if (acc) begin
            cnt_d[in_id]  = cnt_d[in_id] + CNT_ONE;
            tail_d[in_id] = new_slot;
            if (push_empty) head_d[in_id] = new_slot;
            if (in_last)    lcnt_d[in_id] = lcnt_d[in_id] + CNT_ONE;
        end
        for (int u = 0; u < NUM_UIDS; u++) burst_ready[u] = (lcnt_q[u] != '0);
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            data_q[new_slot] <= in_data;
            resp_q[new_slot] <= in_resp;
            last_q[new_slot] <= in_last;
            if (!push_empty) next_q[tail_q[in_id]] <= new_slot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) fl_q[i] <= SLOT_W'(i);
            fl_rd_q <= '0;
            fl_wr_q <= '0;
            free_q  <= CNT_W'(NUM_SLOTS);
            for (int u = 0; u < NUM_UIDS; u++) begin
                head_q[u] <= '0;
                tail_q[u] <= '0;
                cnt_q[u]  <= '0;
                lcnt_q[u] <= '0;
            end
            fst_q  <= F_IDLE;
            fuid_q <= '0;
        end else begin
            if (acc) fl_rd_q <= fl_rd_q + 1'b1;
            if (rm) begin
                fl_q[fl_wr_q] <= rm_slot;
                fl_wr_q       <= fl_wr_q + 1'b1;
            end
            free_q <= free_d;
            for (int u = 0; u < NUM_UIDS; u++) begin
                head_q[u] <= head_d[u];
                tail_q[u] <= tail_d[u];
                cnt_q[u]  <= cnt_d[u];
                lcnt_q[u] <= lcnt_d[u];
            end
            case (fst_q)
                F_IDLE: if (flush_req) begin
                    fst_q  <= F_WALK;
                    fuid_q <= flush_uid;
                end
                F_WALK: if (cnt_q[fuid_q] <= CNT_ONE) fst_q <= F_DONE;
                default: fst_q <= F_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_response_park_pool.sv
// Directed bench for response_park_pool: ordering, interleave, full pool, same-cycle
// pop/push on a one-beat list, flush walk, and asynchronous reset mid-flush.
module tb_response_park_pool;
    localparam int NU = 16, NS = 32, IW = 4, DW = 64, RW = 2, CW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_last;
    logic [IW-1:0] in_id, pop_uid, out_id, flush_uid;
    logic [DW-1:0] in_data, out_data;
    logic [RW-1:0] in_resp, out_resp;
    logic          pop_req, out_valid, out_ready, out_last, pop_ack;
    logic          flush_req, flush_busy, flush_done;
    logic [CW-1:0] free_slots;
    logic [NU-1:0] burst_ready;

    int checks = 0;
    int fails  = 0;

    response_park_pool #(.NUM_UIDS(NU), .NUM_SLOTS(NS), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_data(in_data),
        .in_resp(in_resp), .in_last(in_last),
        .pop_req(pop_req), .pop_uid(pop_uid), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_data(out_data), .out_resp(out_resp), .out_last(out_last),
        .pop_ack(pop_ack),
        .flush_req(flush_req), .flush_uid(flush_uid), .flush_busy(flush_busy),
        .flush_done(flush_done), .free_slots(free_slots), .burst_ready(burst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int id, input logic [63:0] d, input logic l);
        in_valid = 1'b1; in_id = IW'(id); in_data = d; in_resp = 2'b01; in_last = l;
        #1;
        chk("wr_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic pop_chk(input int id, input logic [63:0] d, input logic l, input string tag);
        pop_req = 1'b1; pop_uid = IW'(id); out_ready = 1'b1;
        #1;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_last"}, 64'(out_last), 64'(l));
        step();
        pop_req = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        int busy_n, done_n, rdy_bad, ov_bad;
        logic done_at_end;
        rst_n = 1'b0; in_valid = 0; in_id = 0; in_data = 0; in_resp = 0; in_last = 0;
        pop_req = 0; pop_uid = 0; out_ready = 0; flush_req = 0; flush_uid = 0;
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rst_free", 64'(free_slots), 64'd32);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_pop_ack", 64'(pop_ack), 64'd0);
        chk("rst_busy", 64'(flush_busy), 64'd0);
        chk("rst_done", 64'(flush_done), 64'd0);
        chk("rst_burst", 64'(burst_ready), 64'd0);
        step();

        // Test 1: four beats on UID 3, in-order drain
        for (int i = 0; i < 4; i++) wr(3, 64'h10 + 64'(i), i == 3);
        chk("t1_free", 64'(free_slots), 64'd28);
        chk("t1_burst", 64'(burst_ready), 64'h0008);
        for (int i = 0; i < 4; i++) pop_chk(3, 64'h10 + 64'(i), i == 3, "t1_pop");
        chk("t1_free_after", 64'(free_slots), 64'd32);
        chk("t1_burst_after", 64'(burst_ready), 64'd0);

        // Test 2: interleaved UIDs 1 and 2
        wr(1, 64'hA1, 1'b0); wr(2, 64'hB1, 1'b0); wr(1, 64'hA2, 1'b1); wr(2, 64'hB2, 1'b1);
        chk("t2_burst", 64'(burst_ready), 64'h0006);
        pop_chk(2, 64'hB1, 1'b0, "t2_b1");
        pop_chk(2, 64'hB2, 1'b1, "t2_b2");
        pop_chk(1, 64'hA1, 1'b0, "t2_a1");
        pop_chk(1, 64'hA2, 1'b1, "t2_a2");
        chk("t2_free", 64'(free_slots), 64'd32);
        wr(4, 64'h44, 1'b1);
        pop_chk(4, 64'h44, 1'b1, "t2_reuse");

        // Test 3: full pool on UID 0; freed slot not reused in the same cycle
        for (int i = 0; i < 32; i++) wr(0, 64'h101 + 64'(i), 1'b0);
        chk("t3_free0", 64'(free_slots), 64'd0);
        in_valid = 1'b1; in_id = 0; in_data = 64'h99; in_last = 1'b0;
        pop_req = 1'b1; pop_uid = 0; out_ready = 1'b1;
        #1;
        chk("t3_ready_full", 64'(in_ready), 64'd0);
        chk("t3_pop_ack", 64'(pop_ack), 64'd1);
        chk("t3_pop_data", out_data, 64'h101);
        step();
        pop_req = 1'b0; out_ready = 1'b0;
        #1;
        chk("t3_free1", 64'(free_slots), 64'd1);
        chk("t3_ready_next", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("t3_free0_again", 64'(free_slots), 64'd0);
        for (int i = 1; i < 32; i++) pop_chk(0, 64'h101 + 64'(i), 1'b0, "t3_drain");
        pop_chk(0, 64'h99, 1'b0, "t3_drain_tail");
        chk("t3_free_end", 64'(free_slots), 64'd32);

        // Test 4: one-beat list, same-cycle pop and push on UID 5
        wr(5, 64'h55, 1'b0);
        in_valid = 1'b1; in_id = 5; in_data = 64'hAA; in_last = 1'b1;
        pop_req = 1'b1; pop_uid = 5; out_ready = 1'b1;
        #1;
        chk("t4_old_head", out_data, 64'h55);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("t4_new_head", out_data, 64'hAA);
        chk("t4_new_last", 64'(out_last), 64'd1);
        pop_chk(5, 64'hAA, 1'b1, "t4_pop");
        pop_req = 1'b1; pop_uid = 5;
        #1;
        chk("t4_empty", 64'(out_valid), 64'd0);
        pop_req = 1'b0;
        chk("t4_free", 64'(free_slots), 64'd32);

        // Test 5: flush six beats of UID 7, with a second request mid-walk
        for (int i = 0; i < 6; i++) wr(7, 64'h70 + 64'(i), i == 5);
        chk("t5_free", 64'(free_slots), 64'd26);
        chk("t5_burst", 64'(burst_ready), 64'h0080);
        flush_req = 1'b1; flush_uid = 7;
        step();
        flush_req = 1'b0;
        busy_n = 0; done_n = 0; rdy_bad = 0; ov_bad = 0; done_at_end = 1'b0;
        in_valid = 1'b1; in_id = 9; in_data = 64'hDEAD;
        pop_req = 1'b1; pop_uid = 7; out_ready = 1'b1;
        while (flush_busy && busy_n < 50) begin
            busy_n++;
            if (in_ready) rdy_bad++;
            if (out_valid) ov_bad++;
            if (flush_done) done_n++;
            done_at_end = flush_done;
            flush_req = (busy_n == 3);
            step();
        end
        flush_req = 1'b0; in_valid = 1'b0; pop_req = 1'b0; out_ready = 1'b0;
        #1;
        chk("t5_busy_cycles", 64'(busy_n), 64'd7);
        chk("t5_done_pulses", 64'(done_n), 64'd1);
        chk("t5_done_last", 64'(done_at_end), 64'd1);
        chk("t5_ready_low", 64'(rdy_bad), 64'd0);
        chk("t5_outv_low", 64'(ov_bad), 64'd0);
        chk("t5_free_end", 64'(free_slots), 64'd32);
        chk("t5_burst_end", 64'(burst_ready), 64'd0);
        step(); step();
        chk("t5_no_reflush", 64'(flush_busy), 64'd0);

        // Test 6: async reset mid-flush with ten beats parked on UID 9
        for (int i = 0; i < 10; i++) wr(9, 64'h90 + 64'(i), i == 9);
        flush_req = 1'b1; flush_uid = 9;
        step();
        flush_req = 1'b0;
        step(); step();
        chk("t6_busy_pre", 64'(flush_busy), 64'd1);
        pop_req = 1'b1; pop_uid = 9;
        rst_n = 1'b0;
        #1;
        chk("t6_async_free", 64'(free_slots), 64'd32);
        chk("t6_async_busy", 64'(flush_busy), 64'd0);
        step();
        chk("t6_free", 64'(free_slots), 64'd32);
        chk("t6_outv", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        step();
        chk("t6_post_outv", 64'(out_valid), 64'd0);
        chk("t6_post_burst", 64'(burst_ready), 64'd0);
        chk("t6_post_ready", 64'(in_ready), 64'd1);
        pop_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
